mem_access_ctrl: RTL and testbench

Memory-access sequencer that sits directly upstream of the memory subsystem (MAR, MDR, RAM). It accepts one load or store request from the CPU control path through a valid/ready handshake. It then drives the MAR-load, MDR-load, MDR-read-select and RAM read/write strobes in the correct order for a programmable RAM latency, and returns read data with a one-cycle response pulse.

---
 rtl/mem_access_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer driving MAR/MDR/RAM strobes; `MEM_BOUNDS_CHECK_EN adds out-of-range rejection.
// Latency: load rsp_valid at T+3+WAIT_CYCLES, store at T+2+WAIT_CYCLES (T+1 for a rejected address).
// Backpressure: req_ready only in IDLE, one request in flight, no overlap between accesses.
module mem_access_ctrl #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int MEM_DEPTH   = 512
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              mar_load,
  output logic [ADDR_W-1:0] mar_data,
  output logic              mdr_load,
  output logic              mdr_read,
  output logic [DATA_W-1:0] mdr_data,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_MAR_LD, S_ACCESS, S_CAPTURE, S_RESP
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(WAIT_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_write;
  logic       w_oob;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  assign w_oob = ({1'b0, req_addr} >= LP_DEPTH);
`else
  // Depth only matters to the bounds check; kept visible so the parameter is not dangling.
  wire w_unused_depth = MEM_DEPTH[0];
  assign w_oob   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_write   <= 1'b0;
      req_ready <= 1'b1;
      mar_load  <= 1'b0;
      mar_data  <= '0;
      mdr_load  <= 1'b0;
      mdr_read  <= 1'b0;
      mdr_data  <= '0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef MEM_BOUNDS_CHECK_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      mar_load  <= 1'b0;
      mdr_load  <= 1'b0;
      mdr_read  <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      rsp_valid <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      rsp_err   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            r_write   <= req_write;
            if (w_oob) begin
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
`ifdef MEM_BOUNDS_CHECK_EN
              rsp_err   <= 1'b1;
`endif
            end else begin
              r_state  <= S_MAR_LD;
              mar_load <= 1'b1;
              mar_data <= req_addr;
              if (req_write) begin
                mdr_load <= 1'b1;
                mdr_data <= req_wdata;
              end
            end
          end
        end
        S_MAR_LD: begin
          r_state   <= S_ACCESS;
          r_cnt     <= 4'd0;
          ram_read  <= !r_write;
          ram_write <= r_write;
        end
        S_ACCESS: begin
          if (r_cnt == LP_LAST) begin
            if (r_write) begin
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
            end else begin
              // Read strobe stays up through capture so the MDR sees stable RAM data.
              r_state  <= S_CAPTURE;
              ram_read <= 1'b1;
              mdr_load <= 1'b1;
              mdr_read <= 1'b1;
            end
          end else begin
            r_cnt     <= r_cnt + 4'd1;
            ram_read  <= !r_write;
            ram_write <= r_write;
          end
        end
        S_CAPTURE: begin
          rsp_rdata <= ram_rdata;
          r_state   <= S_RESP;
          rsp_valid <= 1'b1;
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: instance a (WAIT_CYCLES=1, MEM_DEPTH=256) and instance b (WAIT_CYCLES=4).
module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  logic        clear;
  int          n_checks = 0;
  int          n_errors = 0;

  logic        a_req_valid, a_req_write, a_req_ready;
  logic [8:0]  a_req_addr, a_mar_data;
  logic [31:0] a_req_wdata, a_mdr_data, a_ram_rdata, a_rsp_rdata;
  logic        a_mar_load, a_mdr_load, a_mdr_read, a_ram_read, a_ram_write, a_rsp_valid, a_rsp_err;

  logic        b_req_valid, b_req_write, b_req_ready;
  logic [8:0]  b_req_addr, b_mar_data;
  logic [31:0] b_req_wdata, b_mdr_data, b_ram_rdata, b_rsp_rdata;
  logic        b_mar_load, b_mdr_load, b_mdr_read, b_ram_read, b_ram_write, b_rsp_valid, b_rsp_err;

  always #5 clock = ~clock;

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(1), .MEM_DEPTH(256)) u_dut_a (
    .clock(clock), .clear(clear),
    .req_valid(a_req_valid), .req_write(a_req_write), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .req_ready(a_req_ready), .mar_load(a_mar_load), .mar_data(a_mar_data),
    .mdr_load(a_mdr_load), .mdr_read(a_mdr_read), .mdr_data(a_mdr_data),
    .ram_read(a_ram_read), .ram_write(a_ram_write), .ram_rdata(a_ram_rdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(4), .MEM_DEPTH(512)) u_dut_b (
    .clock(clock), .clear(clear),
    .req_valid(b_req_valid), .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_ready(b_req_ready), .mar_load(b_mar_load), .mar_data(b_mar_data),
    .mdr_load(b_mdr_load), .mdr_read(b_mdr_read), .mdr_data(b_mdr_data),
    .ram_read(b_ram_read), .ram_write(b_ram_write), .ram_rdata(b_ram_rdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic test_reset();
    logic [7:0] obs;
    clear = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_ram_rdata = '0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_ram_rdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    obs = {a_req_ready, a_mar_load, a_mdr_load, a_mdr_read, a_ram_read, a_ram_write, a_rsp_valid, a_rsp_err};
    n_checks++;
    if (obs !== 8'b1000_0000) begin
      n_errors++; $display("FAIL reset_ctrl_a: got %b expected %b", obs, 8'b1000_0000);
    end
    n_checks++;
    if ({a_rsp_rdata, a_mdr_data, a_mar_data} !== 73'd0) begin
      n_errors++; $display("FAIL reset_data_a: got %h/%h/%h expected 0", a_rsp_rdata, a_mdr_data, a_mar_data);
    end
    n_checks++;
    if (b_req_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready_b: got %b expected 1", b_req_ready);
    end
  endtask

  task automatic test_load(input logic [8:0] addr, input logic [31:0] data);
    logic [6:0] exp, obs;
    @(negedge clock);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = addr; a_ram_rdata = data;
    @(posedge clock);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k == 1) a_req_valid = 1'b0;
      case (k)
        1:       exp = 7'b1000000;
        2:       exp = 7'b0001000;
        3:       exp = 7'b0111000;
        4:       exp = 7'b0000010;
        default: exp = 7'b0000001;
      endcase
      obs = {a_mar_load, a_mdr_load, a_mdr_read, a_ram_read, a_ram_write, a_rsp_valid, a_req_ready};
      n_checks++;
      if (obs !== exp) begin
        n_errors++; $display("FAIL load_strobes addr=%h cycle %0d: got %b expected %b", addr, k, obs, exp);
      end
      if (k == 1) begin
        n_checks++;
        if (a_mar_data !== addr) begin
          n_errors++; $display("FAIL load_mar_data: got %h expected %h", a_mar_data, addr);
        end
      end
      if (k == 4) begin
        n_checks++;
        if (a_rsp_rdata !== data || a_rsp_err !== 1'b0) begin
          n_errors++; $display("FAIL load_rsp: got %h err %b expected %h err 0", a_rsp_rdata, a_rsp_err, data);
        end
        a_ram_rdata = ~data;
      end
      if (k == 5) begin
        n_checks++;
        if (a_rsp_rdata !== data) begin
          n_errors++; $display("FAIL load_rdata_hold: got %h expected %h", a_rsp_rdata, data);
        end
      end
    end
  endtask

  task automatic test_store(input logic [31:0] prev_rdata);
    logic [6:0] exp, obs;
    @(negedge clock);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 9'h1FF; a_req_wdata = 32'h0000A5A5;
    @(posedge clock);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 1) a_req_valid = 1'b0;
      case (k)
        1:       exp = 7'b1100000;
        2:       exp = 7'b0000100;
        3:       exp = 7'b0000010;
        default: exp = 7'b0000001;
      endcase
      obs = {a_mar_load, a_mdr_load, a_mdr_read, a_ram_read, a_ram_write, a_rsp_valid, a_req_ready};
      n_checks++;
      if (obs !== exp) begin
        n_errors++; $display("FAIL store_strobes cycle %0d: got %b expected %b", k, obs, exp);
      end
      if (k == 1) begin
        n_checks++;
        if (a_mdr_data !== 32'h0000A5A5 || a_mar_data !== 9'h1FF) begin
          n_errors++; $display("FAIL store_data: got mdr %h mar %h expected 0000a5a5 1ff", a_mdr_data, a_mar_data);
        end
      end
      if (k == 3) begin
        n_checks++;
        if (a_rsp_rdata !== prev_rdata) begin
          n_errors++; $display("FAIL store_keeps_rdata: got %h expected %h", a_rsp_rdata, prev_rdata);
        end
      end
    end
  endtask

  task automatic test_long_wait();
    logic [6:0] exp, obs;
    int         n_rd;
    n_rd = 0;
    @(negedge clock);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 9'h055; b_ram_rdata = 32'hCAFEF00D;
    @(posedge clock);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) b_req_valid = 1'b0;
      if (b_ram_read) n_rd++;
      if (k == 1)      exp = 7'b1000000;
      else if (k <= 5) exp = 7'b0001000;
      else if (k == 6) exp = 7'b0111000;
      else if (k == 7) exp = 7'b0000010;
      else             exp = 7'b0000001;
      obs = {b_mar_load, b_mdr_load, b_mdr_read, b_ram_read, b_ram_write, b_rsp_valid, b_req_ready};
      n_checks++;
      if (obs !== exp) begin
        n_errors++; $display("FAIL wait4_strobes cycle %0d: got %b expected %b", k, obs, exp);
      end
      if (k == 7) begin
        n_checks++;
        if (b_rsp_rdata !== 32'hCAFEF00D) begin
          n_errors++; $display("FAIL wait4_rdata: got %h expected cafef00d", b_rsp_rdata);
        end
      end
    end
    n_checks++;
    if (n_rd != 5) begin
      n_errors++; $display("FAIL wait4_read_cycles: got %0d expected 5", n_rd);
    end
  endtask

  task automatic test_abort();
    logic [7:0] obs;
    int         n_rsp;
    n_rsp = 0;
    @(negedge clock);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 9'h010; a_req_wdata = 32'h00000001;
    @(posedge clock);
    @(negedge clock);
    a_req_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (a_ram_write !== 1'b1) begin
      n_errors++; $display("FAIL abort_in_access: got ram_write %b expected 1", a_ram_write);
    end
    clear = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    obs = {a_req_ready, a_mar_load, a_mdr_load, a_mdr_read, a_ram_read, a_ram_write, a_rsp_valid, a_rsp_err};
    n_checks++;
    if (obs !== 8'b1000_0000 || {a_rsp_rdata, a_mdr_data, a_mar_data} !== 73'd0) begin
      n_errors++; $display("FAIL abort_reset_state: got %b data %h/%h/%h expected 10000000 and zeros",
                           obs, a_rsp_rdata, a_mdr_data, a_mar_data);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (a_rsp_valid) n_rsp++;
    end
    n_checks++;
    if (n_rsp != 0) begin
      n_errors++; $display("FAIL abort_no_rsp: got %0d responses expected 0", n_rsp);
    end
  endtask

  task automatic test_back_to_back();
    int   n_acc, last_c, gap;
    logic last_w, prev_rsp, done;
    n_acc = 0; last_c = 0; last_w = 1'b0; prev_rsp = 1'b0; done = 1'b0;
    a_ram_rdata = 32'h0BADF00D;
    for (int c = 0; c < 40 && n_acc < 6; c++) begin
      @(negedge clock);
      if (a_ram_read && a_ram_write) begin
        n_checks++; n_errors++; $display("FAIL b2b_overlap: read and write both high at cycle %0d", c);
      end
      if (a_req_ready) begin
        if (n_acc > 0) begin
          gap = last_w ? 4 : 5;
          n_checks++;
          if (c - last_c != gap || prev_rsp !== 1'b1) begin
            n_errors++; $display("FAIL b2b_spacing: got gap %0d prev_rsp %b expected %0d and 1", c - last_c, prev_rsp, gap);
          end
        end
        n_checks++;
        if ({a_mar_load, a_mdr_load, a_ram_read, a_ram_write, a_rsp_valid} !== 5'b0) begin
          n_errors++; $display("FAIL b2b_idle_strobes: got %b expected 00000",
                               {a_mar_load, a_mdr_load, a_ram_read, a_ram_write, a_rsp_valid});
        end
        a_req_valid = 1'b1;
        a_req_write = (n_acc % 2) == 1;
        a_req_addr  = 9'(n_acc * 7);
        a_req_wdata = 32'(n_acc);
        last_c = c; last_w = a_req_write;
        n_acc++;
      end
      prev_rsp = a_rsp_valid;
    end
    n_checks++;
    if (n_acc != 6) begin
      n_errors++; $display("FAIL b2b_accept_count: got %0d expected 6", n_acc);
    end
    @(posedge clock);
    #1 a_req_valid = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clock);
      if (a_req_ready) done = 1'b1;
    end
    n_checks++;
    if (!done || a_rsp_rdata !== 32'h0BADF00D) begin
      n_errors++; $display("FAIL b2b_drain: got ready %b rdata %h expected 1 0badf00d", done, a_rsp_rdata);
    end
  endtask

  task automatic test_bounds();
`ifdef MEM_BOUNDS_CHECK_EN
    logic [7:0] obs;
    @(negedge clock);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 9'h100; a_ram_rdata = 32'h11111111;
    @(posedge clock);
    @(negedge clock);
    a_req_valid = 1'b0;
    obs = {a_req_ready, a_mar_load, a_mdr_load, a_mdr_read, a_ram_read, a_ram_write, a_rsp_valid, a_rsp_err};
    n_checks++;
    if (obs !== 8'b0000_0011) begin
      n_errors++; $display("FAIL bounds_reject: got %b expected 00000011", obs);
    end
    n_checks++;
    if (a_rsp_rdata !== 32'h0BADF00D) begin
      n_errors++; $display("FAIL bounds_rdata_kept: got %h expected 0badf00d", a_rsp_rdata);
    end
    @(negedge clock);
    n_checks++;
    if (a_req_ready !== 1'b1 || a_rsp_err !== 1'b0) begin
      n_errors++; $display("FAIL bounds_return_idle: got ready %b err %b expected 1 0", a_req_ready, a_rsp_err);
    end
`else
    test_load(9'h100, 32'h11111111);
`endif
    test_load(9'h0FF, 32'h00FF00FF);
  endtask

  initial begin
    test_reset();
    test_load(9'h012, 32'hDEADBEEF);
    test_store(32'hDEADBEEF);
    test_long_wait();
    test_abort();
    test_back_to_back();
    test_bounds();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
